ps2_rx: RTL and testbench
=========================

# ps2_rx

PS/2 keyboard receiver that deserialises the keyboard's clock/data lines into 8-bit scan codes and tracks make/break sequences. It sits directly upstream of the scan-code-to-direction decoder. It drives a held 8-bit key code that the decoder maps to its 4-bit direction output (1C/1B/23/2B → one-hot). Key code is held while a key is down and forced to 8'h00 on release, so the decoder falls back to 4'b0000.

## Interface
- FILTER_LEN, 8: consecutive identical synchronised samples required before the filtered PS/2 clock level changes (1..255).
- TIMEOUT_CYC, 50000: clk cycles without a falling PS/2 clock edge, mid-frame, after which the frame is abandoned.
- clk  in  1  system clock (50 MHz nominal); all logic on rising edge.
- reset  in  1  asynchronous, active-high; clears all state and outputs.
- ps2c  in  1  raw PS/2 clock pin, asynchronous.
- ps2d  in  1  raw PS/2 data pin, asynchronous.
- code_o  out  8  held key code: last make code, 8'h00 when released/none.
- rx_done_tick  out  1  one-cycle pulse per accepted frame.
- rx_data  out  8  raw byte of the last accepted frame (includes F0/E0).
- frame_err  out  1  one-cycle pulse on rejected frame (bad start/stop/parity, or timeout).

## Operation
- Both pins pass through 2-flop synchronisers. Synchronised ps2c feeds a filter counter: the filtered level flips only after FILTER_LEN consecutive samples differ from it. The counter resets on any matching sample.
- Falling edge (fall_tick) = filtered level 1 in previous cycle, 0 now. Synchronised ps2d is sampled on fall_tick.
- FSM states:
  - IDLE → RX on fall_tick; captures bit 0 (start); bit counter = 1; timeout counter cleared.
  - RX: shifts ps2d into an 11-bit register on each fall_tick, LSB first, and increments the bit counter. After the 11th bit goes to CHECK. Timeout counter increments every cycle without fall_tick; reaching TIMEOUT_CYC → frame_err, IDLE.
  - CHECK (1 cycle): start==0 and stop==1 (plus parity, see Configuration) → rx_data updated, rx_done_tick, make/break processing; else frame_err. Then IDLE.
- Make/break processing on accepted byte B:
  - B==F0 → brk flag set; code_o unchanged.
  - B==E0 → ignored (no flag change, code_o unchanged).
  - Other B with brk set → brk cleared. If B==code_o, code_o = 00; otherwise code_o unchanged.
  - Other B with brk clear → code_o = B. Typematic repeats of the same code are harmless.
- Reset (any time, including mid-frame): state IDLE, shift register 0, counters 0, brk 0, filtered level 1, synchronisers 1. Outputs: code_o=00, rx_data=00, rx_done_tick=0, frame_err=0.

## Timing
- Pin to filtered edge: 2 sync cycles + FILTER_LEN cycles.
- rx_done_tick / frame_err asserted exactly 1 cycle after the fall_tick of bit 11. rx_data and code_o take their new values in that same cycle and hold until the next accepted frame.
- Never more than one of rx_done_tick and frame_err per frame; never back-to-back.
- A fall_tick during CHECK is ignored; a new start bit is accepted from IDLE onward.
- Glitches shorter than FILTER_LEN cycles on ps2c produce no fall_tick.
- Timeout applies only in RX; IDLE waits indefinitely.

## Configuration
- PS2_PARITY_CHECK_EN defined: CHECK also requires odd parity over data bits 1..8 plus parity bit 9. A mismatch gives frame_err; no rx_done_tick, code_o and brk unchanged.
- Not defined: bit 9 is ignored; only start and stop are checked.

## Test plan
- Frame 1C (data 00111000 LSB-first, parity 0, stop 1) at 12.5 kHz PS/2 clock → rx_done_tick once, rx_data=1C, code_o=1C.
- Sequence 1D, F0, 1D → code_o 1D after byte 1; stays 1D after F0; 00 after final byte; three rx_done_tick pulses.
- Sequence 23, F0, 2B → code_o stays 23 (release of non-held key); brk cleared afterwards; next 2B → code_o=2B.
- Frame 1B with parity bit inverted → with PS2_PARITY_CHECK_EN: frame_err, code_o unchanged. Without it: rx_done_tick, code_o=1B.
- Stop only 5 falling edges, then idle > TIMEOUT_CYC → frame_err once, FSM in IDLE; the following good frame 2B gives code_o=2B. Also: 3-cycle ps2c glitch (FILTER_LEN=8) → no bit captured.
- Assert reset mid-frame after code_o=1C → all outputs 0 immediately (asynchronous); the next complete frame 1C is received correctly.

Source files
------------

// File: rtl/ps2_rx.sv
// PS/2 keyboard receiver: synchronises and filters the PS/2 clock, deserialises
// 11-bit frames and tracks make/break codes. Define PS2_PARITY_CHECK_EN to enforce odd parity.
module ps2_rx #(
  parameter int unsigned FILTER_LEN  = 8,
  parameter int unsigned TIMEOUT_CYC = 50000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ps2c,
  input  logic       ps2d,
  output logic [7:0] code_o,
  output logic       rx_done_tick,
  output logic [7:0] rx_data,
  output logic       frame_err
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RX    = 2'd1;
  localparam logic [1:0] S_CHECK = 2'd2;

  localparam int unsigned   TW      = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYC - 1);
  localparam logic [TW-1:0] TO_ONE  = TW'(1);
  localparam logic [7:0]    F_LAST  = 8'(FILTER_LEN - 1);

  logic          r_c_s1, r_c_s2, r_d_s1, r_d_s2;
  logic          r_filt, r_filt_d;
  logic [7:0]    r_fcnt;
  logic [1:0]    r_state;
  logic [9:0]    r_shift;
  logic [3:0]    r_bitcnt;
  logic [TW-1:0] r_tocnt;
  logic          r_brk;
  logic [7:0]    r_code;
  logic [7:0]    r_data;
  logic          r_done;
  logic          r_err;

  logic          w_fall;
  logic [7:0]    w_byte;
  logic          w_par_ok;
  logic          w_ok;

  assign code_o       = r_code;
  assign rx_data      = r_data;
  assign rx_done_tick = r_done;
  assign frame_err    = r_err;

  assign w_fall = r_filt_d & ~r_filt;

  // The first ten bits live in r_shift; the stop bit is judged straight off the
  // synchroniser so the result registers on the same edge as the last fall_tick.
  assign w_byte = r_shift[8:1];
`ifdef PS2_PARITY_CHECK_EN
  assign w_par_ok = ^r_shift[9:1];
`else
  assign w_par_ok = 1'b1;
`endif
  assign w_ok = ~r_shift[0] & r_d_s2 & w_par_ok;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_c_s1   <= 1'b1;
      r_c_s2   <= 1'b1;
      r_d_s1   <= 1'b1;
      r_d_s2   <= 1'b1;
      r_filt   <= 1'b1;
      r_filt_d <= 1'b1;
      r_fcnt   <= '0;
    end else begin
      r_c_s1   <= ps2c;
      r_c_s2   <= r_c_s1;
      r_d_s1   <= ps2d;
      r_d_s2   <= r_d_s1;
      r_filt_d <= r_filt;
      if (r_c_s2 == r_filt) begin
        r_fcnt <= '0;
      end else if (r_fcnt == F_LAST) begin
        r_filt <= r_c_s2;
        r_fcnt <= '0;
      end else begin
        r_fcnt <= r_fcnt + 8'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_shift  <= '0;
      r_bitcnt <= '0;
      r_tocnt  <= '0;
      r_brk    <= 1'b0;
      r_code   <= '0;
      r_data   <= '0;
      r_done   <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      r_err  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_fall) begin
            r_shift  <= {r_d_s2, r_shift[9:1]};
            r_bitcnt <= 4'd1;
            r_tocnt  <= '0;
            r_state  <= S_RX;
          end
        end
        S_RX: begin
          if (w_fall) begin
            r_tocnt <= '0;
            if (r_bitcnt == 4'd10) begin
              r_bitcnt <= 4'd11;
              r_state  <= S_CHECK;
              if (w_ok) begin
                r_done <= 1'b1;
                r_data <= w_byte;
                if (w_byte == 8'hF0) begin
                  r_brk <= 1'b1;
                end else if (w_byte != 8'hE0) begin
                  if (r_brk) begin
                    r_brk <= 1'b0;
                    if (w_byte == r_code) r_code <= 8'h00;
                  end else begin
                    r_code <= w_byte;
                  end
                end
              end else begin
                r_err <= 1'b1;
              end
            end else begin
              r_shift  <= {r_d_s2, r_shift[9:1]};
              r_bitcnt <= r_bitcnt + 4'd1;
            end
          end else if (r_tocnt == TO_LAST) begin
            r_err   <= 1'b1;
            r_state <= S_IDLE;
          end else begin
            r_tocnt <= r_tocnt + TO_ONE;
          end
        end
        S_CHECK: r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ps2_rx.sv
// Self-checking bench for ps2_rx: directed frames plus random frames against a make/break model.
module tb_ps2_rx;
  localparam int unsigned FL = 8;
  localparam int unsigned TO = 1000;
  localparam int unsigned HP = 25;

  logic       clk = 1'b0;
  logic       reset;
  logic       ps2c;
  logic       ps2d;
  logic [7:0] code_o;
  logic       rx_done_tick;
  logic [7:0] rx_data;
  logic       frame_err;

  always #5 clk = ~clk;

  ps2_rx #(.FILTER_LEN(FL), .TIMEOUT_CYC(TO)) dut (
    .clk(clk), .reset(reset), .ps2c(ps2c), .ps2d(ps2d),
    .code_o(code_o), .rx_done_tick(rx_done_tick), .rx_data(rx_data), .frame_err(frame_err)
  );

  int          n_assert = 0;
  int          n_fail   = 0;
  int unsigned cyc      = 0;
  int unsigned fall_cyc = 0;
  int unsigned tick_cyc = 0;
  int          n_done   = 0;
  int          n_err    = 0;
  int          n_overlap = 0;
  logic        prev_pulse = 1'b0;

  logic [7:0]  m_code = 8'h00;
  logic [7:0]  m_data = 8'h00;
  bit          m_brk  = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rx_done_tick === 1'b1) n_done++;
    if (frame_err === 1'b1) n_err++;
    if (rx_done_tick === 1'b1 || frame_err === 1'b1) begin
      if ((rx_done_tick === 1'b1 && frame_err === 1'b1) || prev_pulse) n_overlap++;
      tick_cyc = cyc;
    end
    prev_pulse = (rx_done_tick === 1'b1) || (frame_err === 1'b1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [10:0] mkframe(input logic [7:0] b, input logic bad_start,
                                          input logic bad_par, input logic bad_stop);
    return {~bad_stop, (~^b) ^ bad_par, b, bad_start};
  endfunction

  task automatic send_bits(input logic [10:0] bits, input int unsigned nbits);
    for (int unsigned i = 0; i < nbits; i++) begin
      @(negedge clk);
      ps2d = bits[i];
      repeat (HP) @(negedge clk);
      ps2c = 1'b0;
      fall_cyc = cyc;
      repeat (HP) @(negedge clk);
      ps2c = 1'b1;
    end
    @(negedge clk);
    ps2d = 1'b1;
  endtask

  task automatic model_accept(input logic [7:0] b);
    m_data = b;
    if (b == 8'hF0) m_brk = 1'b1;
    else if (b != 8'hE0) begin
      if (m_brk) begin
        m_brk = 1'b0;
        if (b == m_code) m_code = 8'h00;
      end else begin
        m_code = b;
      end
    end
  endtask

  task automatic frame_check(input string tag, input logic [7:0] b, input logic bs,
                             input logic bp, input logic bst);
    int d0;
    int e0;
    bit acc;
    d0 = n_done;
    e0 = n_err;
    send_bits(mkframe(b, bs, bp, bst), 11);
    repeat (FL + 20) @(negedge clk);
    acc = !bs && !bst;
`ifdef PS2_PARITY_CHECK_EN
    acc = acc && !bp;
`endif
    if (acc) model_accept(b);
    chk({tag, ".done"}, 32'(n_done - d0), acc ? 32'd1 : 32'd0);
    chk({tag, ".err"}, 32'(n_err - e0), acc ? 32'd0 : 32'd1);
    chk({tag, ".latency"}, 32'(tick_cyc - fall_cyc), 32'(FL + 3));
    chk({tag, ".rx_data"}, {24'h0, rx_data}, {24'h0, m_data});
    chk({tag, ".code_o"}, {24'h0, code_o}, {24'h0, m_code});
  endtask

  initial begin
    int d0;
    int e0;
    logic [7:0] tbl [8];
    logic [7:0] b;
    int unsigned r;
    tbl[0] = 8'h1C; tbl[1] = 8'h1B; tbl[2] = 8'h23; tbl[3] = 8'h2B;
    tbl[4] = 8'h1D; tbl[5] = 8'hF0; tbl[6] = 8'hF0; tbl[7] = 8'hE0;

    reset = 1'b1;
    ps2c  = 1'b1;
    ps2d  = 1'b1;
    repeat (4) @(negedge clk);
    chk("rst.code_o", {24'h0, code_o}, 32'h0);
    chk("rst.rx_data", {24'h0, rx_data}, 32'h0);
    chk("rst.done", {31'h0, rx_done_tick}, 32'h0);
    chk("rst.err", {31'h0, frame_err}, 32'h0);
    reset = 1'b0;
    repeat (5) @(negedge clk);

    frame_check("f1C", 8'h1C, 1'b0, 1'b0, 1'b0);

    frame_check("s1.1D", 8'h1D, 1'b0, 1'b0, 1'b0);
    frame_check("s1.F0", 8'hF0, 1'b0, 1'b0, 1'b0);
    frame_check("s1.1D_rel", 8'h1D, 1'b0, 1'b0, 1'b0);

    frame_check("s2.23", 8'h23, 1'b0, 1'b0, 1'b0);
    frame_check("s2.F0", 8'hF0, 1'b0, 1'b0, 1'b0);
    frame_check("s2.2B_rel", 8'h2B, 1'b0, 1'b0, 1'b0);
    frame_check("s2.2B", 8'h2B, 1'b0, 1'b0, 1'b0);

    frame_check("e0", 8'hE0, 1'b0, 1'b0, 1'b0);
    frame_check("par1B", 8'h1B, 1'b0, 1'b1, 1'b0);
    frame_check("badstart", 8'h23, 1'b1, 1'b0, 1'b0);
    frame_check("badstop", 8'h23, 1'b0, 1'b0, 1'b1);

    // Truncated frame: five bits then silence past the timeout.
    d0 = n_done;
    e0 = n_err;
    send_bits(mkframe(8'h1C, 1'b0, 1'b0, 1'b0), 5);
    repeat (TO + 50) @(negedge clk);
    chk("timeout.err", 32'(n_err - e0), 32'd1);
    chk("timeout.done", 32'(n_done - d0), 32'd0);
    chk("timeout.code_o", {24'h0, code_o}, {24'h0, m_code});
    frame_check("after_to.2B", 8'h2B, 1'b0, 1'b0, 1'b0);

    // Short ps2c glitch must not start a frame.
    d0 = n_done;
    e0 = n_err;
    @(negedge clk);
    ps2c = 1'b0;
    repeat (3) @(negedge clk);
    ps2c = 1'b1;
    repeat (40) @(negedge clk);
    chk("glitch.err", 32'(n_err - e0), 32'd0);
    chk("glitch.done", 32'(n_done - d0), 32'd0);
    frame_check("after_glitch.1C", 8'h1C, 1'b0, 1'b0, 1'b0);

    // Asynchronous reset in the middle of a frame.
    send_bits(mkframe(8'h23, 1'b0, 1'b0, 1'b0), 4);
    #2;
    reset = 1'b1;
    #1;
    chk("midrst.code_o", {24'h0, code_o}, 32'h0);
    chk("midrst.rx_data", {24'h0, rx_data}, 32'h0);
    chk("midrst.done", {31'h0, rx_done_tick}, 32'h0);
    chk("midrst.err", {31'h0, frame_err}, 32'h0);
    m_code = 8'h00;
    m_data = 8'h00;
    m_brk  = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (5) @(negedge clk);
    frame_check("after_rst.1C", 8'h1C, 1'b0, 1'b0, 1'b0);

    for (int i = 0; i < 30; i++) begin
      r = $urandom_range(0, 9);
      if ($urandom_range(0, 4) == 0) b = 8'($urandom);
      else b = tbl[$urandom_range(0, 7)];
      frame_check("rand", b, r == 0, r == 2, r == 1);
    end

    chk("no_overlap", 32'(n_overlap), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
